inject_ctrl: RTL and testbench

INJECT_CTRL -- requirements
Module: inject_ctrl

---
 rtl/inject_ctrl_if.sv | 26 ++
 rtl/inject_ctrl.sv | 149 ++++++++++++++
 tb/tb_inject_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/inject_ctrl_if.sv
// Local-core injection port of a mesh router: header offer, link slot occupancy,
// injection report and controller status.
interface inject_ctrl_if;
  logic       req_valid;
  logic [5:0] req_addr;
  logic       req_ready;
  logic [3:0] slot_busy;
  logic       inj_valid;
  logic [3:0] inj_slot;
  logic [5:0] inj_addr;
  logic [4:0] inj_dir;
  logic       starve;
  logic [2:0] fifo_count;

  // Core/link side: offers headers and reports slot occupancy.
  modport master (
    output req_valid, req_addr, slot_busy,
    input  req_ready, inj_valid, inj_slot, inj_addr, inj_dir, starve, fifo_count
  );

  // Injection controller side.
  modport slave (
    input  req_valid, req_addr, slot_busy,
    output req_ready, inj_valid, inj_slot, inj_addr, inj_dir, starve, fifo_count
  );
endinterface

// File: rtl/inject_ctrl.sv
// Router injection controller: queues local packet headers, injects the head onto
// a free link slot chosen round-robin, computes XY route and flags starvation.
module inject_ctrl #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter logic [2:0]  LOCAL_ROW    = 3'd4,
  parameter logic [2:0]  LOCAL_COL    = 3'd4
) (
  input  logic          clk,
  input  logic          rst_n,
  inject_ctrl_if.slave  bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [2:0]       DEPTH_C  = 3'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] LIMIT_C  = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, PEND, STARVE} state_t;

  state_t           state_q, state_d;
  logic [5:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0]       count_q, count_d;
  logic [1:0]       rr_ptr_q;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  logic             req_ready;
  logic             push, pop, all_busy;
  logic [5:0]       head_addr;
  logic [7:0]       free2;
  logic [3:0]       free_rot;
  logic [1:0]       offset, sel_idx;
  logic [3:0]       sel_onehot;

  logic             inj_valid_q;
  logic [3:0]       inj_slot_q;
  logic [5:0]       inj_addr_q;
  logic [4:0]       inj_dir_q;

  function automatic logic [4:0] route(input logic [5:0] addr);
    logic [2:0] row, col;
    row = addr[5:3];
    col = addr[2:0];
    if (col > LOCAL_COL)      return 5'b00001;
    else if (col < LOCAL_COL) return 5'b00010;
    else if (row > LOCAL_ROW) return 5'b00100;
    else if (row < LOCAL_ROW) return 5'b01000;
    else                      return 5'b10000;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign all_busy  = (bus.slot_busy == 4'b1111);
  assign req_ready = (count_q < DEPTH_C) && (state_q != STARVE);
  assign push      = bus.req_valid && req_ready;
  assign pop       = (count_q != 3'd0) && !all_busy;
  assign head_addr = mem[rd_ptr_q];

  // Rotate the free mask so bit 0 is the slot at rr_ptr; lowest set bit wins.
  assign free2    = {~bus.slot_busy, ~bus.slot_busy};
  assign free_rot = free2[rr_ptr_q +: 4];

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    offset = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (free_rot[k]) offset = 2'(k);
    end
  end

  assign sel_idx    = rr_ptr_q + offset;
  assign sel_onehot = 4'b0001 << sel_idx;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // Blocked cycles only accrue while something waits and no slot is free.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (count_q == 3'd0 || pop)
      starve_cnt_d = '0;
    else if (all_busy && starve_cnt_q != LIMIT_C)
      starve_cnt_d = starve_cnt_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (push) state_d = PEND;
      PEND:    if (pop && count_d == 3'd0)      state_d = IDLE;
               else if (starve_cnt_d == LIMIT_C) state_d = STARVE;
      STARVE:  if (pop) state_d = (count_d == 3'd0) ? IDLE : PEND;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the packet storage has no reset; emptiness is tracked by count and pointers alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus.req_addr;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= 3'd0;
      rr_ptr_q     <= 2'd0;
      starve_cnt_q <= '0;
      inj_valid_q  <= 1'b0;
      inj_slot_q   <= 4'd0;
      inj_addr_q   <= 6'd0;
      inj_dir_q    <= 5'd0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      starve_cnt_q <= starve_cnt_d;
      inj_valid_q  <= pop;
      inj_slot_q   <= pop ? sel_onehot : 4'd0;
      inj_dir_q    <= pop ? route(head_addr) : 5'd0;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop) begin
        rd_ptr_q   <= ptr_inc(rd_ptr_q);
        rr_ptr_q   <= sel_idx + 2'd1;
        inj_addr_q <= head_addr;
      end
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.inj_valid  = inj_valid_q;
  assign bus.inj_slot   = inj_slot_q;
  assign bus.inj_addr   = inj_addr_q;
  assign bus.inj_dir    = inj_dir_q;
  assign bus.starve     = (state_q == STARVE);
  assign bus.fifo_count = count_q;

endmodule

// File: tb/tb_inject_ctrl.sv
// Directed bench for inject_ctrl: a reference model predicts each edge and a
// queue of expected headers is checked against every injection.
module tb_inject_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inject_ctrl_if bus_if ();

  inject_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int n_vec  = 0;
  int n_miss = 0;

  logic [5:0] exp_q [$];
  int         cnt_m, rr_m, sc_m;
  logic       starve_m;
  logic [5:0] last_addr_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] route_of(input logic [5:0] a);
    if (a[2:0] > 3'd4) return 5'b00001;
    if (a[2:0] < 3'd4) return 5'b00010;
    if (a[5:3] > 3'd4) return 5'b00100;
    if (a[5:3] < 3'd4) return 5'b01000;
    return 5'b10000;
  endfunction

  task automatic model_clear();
    cnt_m = 0; rr_m = 0; sc_m = 0; starve_m = 1'b0; last_addr_m = 6'd0;
    exp_q.delete();
  endtask

  // Reset asserted wherever the caller happens to be in the cycle.
  task automatic apply_reset();
    rst_n = 1'b0;
    bus_if.req_valid = 1'b0;
    bus_if.req_addr  = 6'd0;
    bus_if.slot_busy = 4'd0;
    model_clear();
    #1;
    check("rst_count",     bus_if.fifo_count, 0);
    check("rst_starve",    bus_if.starve,     0);
    check("rst_inj_valid", bus_if.inj_valid,  0);
    check("rst_inj_slot",  bus_if.inj_slot,   0);
    check("rst_inj_addr",  bus_if.inj_addr,   0);
    check("rst_inj_dir",   bus_if.inj_dir,    0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: drive inputs, predict the edge, then compare every output.
  task automatic step(input logic v, input logic [5:0] a, input logic [3:0] busy);
    logic       ready_m, push_m, pop_m, found;
    logic [3:0] slot_m;
    logic [5:0] got;
    int         idx, nxt_rr;
    bus_if.req_valid = v;
    bus_if.req_addr  = a;
    bus_if.slot_busy = busy;
    ready_m = (cnt_m < 4) && !starve_m;
    check("req_ready", bus_if.req_ready, ready_m);
    push_m = v && ready_m;
    pop_m  = (cnt_m > 0) && (busy != 4'hf);
    slot_m = 4'd0;
    found  = 1'b0;
    nxt_rr = rr_m;
    if (pop_m) begin
      for (int k = 0; k < 4; k++) begin
        idx = (rr_m + k) % 4;
        if (!found && !busy[idx]) begin
          found  = 1'b1;
          slot_m = 4'(1 << idx);
          nxt_rr = (idx + 1) % 4;
        end
      end
    end
    if (push_m) exp_q.push_back(a);

    @(posedge clk);
    #1;
    if (cnt_m == 0 || pop_m) sc_m = 0;
    else if (busy == 4'hf && sc_m < 8) sc_m++;
    if (pop_m) starve_m = 1'b0;
    else if (sc_m == 8) starve_m = 1'b1;
    cnt_m = cnt_m + int'(push_m) - int'(pop_m);
    rr_m  = nxt_rr;

    check("inj_valid",  bus_if.inj_valid,  pop_m);
    check("inj_slot",   bus_if.inj_slot,   slot_m);
    check("fifo_count", bus_if.fifo_count, cnt_m);
    check("starve",     bus_if.starve,     starve_m);
    if (bus_if.inj_valid === 1'b1 && exp_q.size() > 0) begin
      got = exp_q.pop_front();
      last_addr_m = got;
      check("inj_addr", bus_if.inj_addr, got);
      check("inj_dir",  bus_if.inj_dir,  route_of(got));
    end else begin
      check("inj_addr_hold", bus_if.inj_addr, last_addr_m);
      check("inj_dir_idle",  bus_if.inj_dir,  0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    apply_reset();
    step(1'b0, 6'd0, 4'd0);

    // Four headers, one per direction, streamed back-to-back on free links.
    step(1'b1, 6'o46, 4'd0);
    step(1'b1, 6'o42, 4'd0);
    step(1'b1, 6'o64, 4'd0);
    step(1'b1, 6'o24, 4'd0);
    step(1'b0, 6'd0,  4'd0);
    step(1'b0, 6'd0,  4'd0);

    // Self-addressed header: no bypass on push edge, local route next edge.
    step(1'b1, 6'o44, 4'd0);
    step(1'b0, 6'd0,  4'd0);

    // Move rr_ptr to 2, then only south is free past it.
    step(1'b1, 6'o43, 4'd0);
    step(1'b0, 6'd0,  4'd0);
    step(1'b1, 6'o05, 4'd0);
    step(1'b0, 6'd0,  4'b0100);

    // Fill under full blockage, ride into starvation, release north only.
    step(1'b1, 6'o47, 4'hf);
    step(1'b1, 6'o41, 4'hf);
    step(1'b1, 6'o74, 4'hf);
    step(1'b1, 6'o14, 4'hf);
    repeat (6) step(1'b1, 6'o33, 4'hf);
    step(1'b0, 6'd0, 4'b1011);

    // Hold count at 2 with push+pop each edge so the pointers wrap.
    step(1'b0, 6'd0, 4'd0);
    for (int i = 0; i < 6; i++) step(1'b1, 6'(8 * i + 3 + i), 4'd0);
    repeat (3) step(1'b0, 6'd0, 4'd0);

    // Starve with a full queue, then reset mid-cycle.
    step(1'b1, 6'o11, 4'hf);
    step(1'b1, 6'o22, 4'hf);
    step(1'b1, 6'o55, 4'hf);
    step(1'b1, 6'o66, 4'hf);
    repeat (6) step(1'b0, 6'd0, 4'hf);
    #3;
    apply_reset();
    step(1'b0, 6'd0,  4'd0);
    step(1'b1, 6'o44, 4'd0);
    step(1'b0, 6'd0,  4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
